gpio_tlul_irq: RTL and testbench

GPIO_TLUL_IRQ -- requirements
Module: gpio_tlul_irq

---
 rtl/gpio_tlul_irq.sv | 223 ++++++++++++++++++++++
 tb/tb_gpio_tlul_irq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_tlul_irq.sv
// TL-UL slave GPIO: OUT/OE/SET/CLR registers and a 2-flop input synchronizer.
// Edge interrupts (registers 5-7, irq_o) are built only when GPIO_IRQ_EN is defined.
module gpio_tlul_irq #(
  parameter int WIDTH = 16,
  parameter int TL_RS = 4
) (
  input  logic             gpio_clock_i,
  input  logic             gpio_reset_ni,
  input  logic [2:0]       gpio_a_opcode,
  input  logic [2:0]       gpio_a_param,
  input  logic [3:0]       gpio_a_size,
  input  logic [TL_RS-1:0] gpio_a_source,
  input  logic [4:0]       gpio_a_address,
  input  logic [3:0]       gpio_a_mask,
  input  logic [31:0]      gpio_a_data,
  input  logic             gpio_a_corrupt,
  input  logic             gpio_a_valid,
  output logic             gpio_a_ready,
  output logic [2:0]       gpio_d_opcode,
  output logic [1:0]       gpio_d_param,
  output logic [3:0]       gpio_d_size,
  output logic [TL_RS-1:0] gpio_d_source,
  output logic             gpio_d_denied,
  output logic [31:0]      gpio_d_data,
  output logic             gpio_d_corrupt,
  output logic             gpio_d_valid,
  input  logic             gpio_d_ready,
  output logic [WIDTH-1:0] outputs_o,
  output logic [WIDTH-1:0] oe_o,
  input  logic [WIDTH-1:0] inputs_i,
  output logic             irq_o
);
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  localparam logic [2:0] REG_OUT      = 3'd0;
  localparam logic [2:0] REG_IN       = 3'd1;
  localparam logic [2:0] REG_OE       = 3'd2;
  localparam logic [2:0] REG_OUT_SET  = 3'd3;
  localparam logic [2:0] REG_OUT_CLR  = 3'd4;
  localparam logic [2:0] REG_IRQ_EN   = 3'd5;
  localparam logic [2:0] REG_IRQ_PEND = 3'd6;
  localparam logic [2:0] REG_IRQ_RISE = 3'd7;

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    return 32'(v);
  endfunction

  logic [WIDTH-1:0] out_r, oe_r, in_meta_r, in_sync_r;
  logic             d_valid_r, d_denied_r;
  logic [2:0]       d_opcode_r;
  logic [3:0]       d_size_r;
  logic [TL_RS-1:0] d_source_r;
  logic [31:0]      d_data_r;

  logic             a_ready_s, accept_s, legal_s, is_write_s, is_read_s;
  logic [2:0]       reg_idx_s;
  logic [31:0]      bmask_s, wbits_s, rdata_s;
  logic [WIDTH-1:0] wdata_s, wmask_s, out_nxt_s, oe_nxt_s;
  logic [WIDTH-1:0] irq_en_s, irq_pend_s, irq_rise_s;
  logic             unused_s;

  assign a_ready_s  = !d_valid_r | gpio_d_ready;
  assign accept_s   = gpio_a_valid & a_ready_s;
  assign reg_idx_s  = gpio_a_address[4:2];
  assign legal_s    = (gpio_a_opcode == OP_PUT_FULL) | (gpio_a_opcode == OP_PUT_PARTIAL) |
                      (gpio_a_opcode == OP_GET);
  assign is_write_s = accept_s & ((gpio_a_opcode == OP_PUT_FULL) | (gpio_a_opcode == OP_PUT_PARTIAL));
  assign is_read_s  = accept_s & (gpio_a_opcode == OP_GET);
  assign bmask_s    = byte_mask(gpio_a_mask);
  assign wbits_s    = gpio_a_data & bmask_s;
  assign wdata_s    = wbits_s[WIDTH-1:0];
  assign wmask_s    = bmask_s[WIDTH-1:0];
  assign unused_s   = ^{gpio_a_param, gpio_a_corrupt, gpio_a_address[1:0], wbits_s, bmask_s};

  // Read mux, sampled into the response register at acceptance
  always_comb begin
    rdata_s = 32'd0;
    case (reg_idx_s)
      REG_OUT:      rdata_s = zext(out_r);
      REG_IN:       rdata_s = zext(in_sync_r);
      REG_OE:       rdata_s = zext(oe_r);
      REG_OUT_SET:  rdata_s = 32'd0;
      REG_OUT_CLR:  rdata_s = 32'd0;
      REG_IRQ_EN:   rdata_s = zext(irq_en_s);
      REG_IRQ_PEND: rdata_s = zext(irq_pend_s);
      REG_IRQ_RISE: rdata_s = zext(irq_rise_s);
      default:      rdata_s = 32'd0;
    endcase
  end

  // Next-state of the pin drive and output-enable registers
  always_comb begin
    out_nxt_s = out_r;
    oe_nxt_s  = oe_r;
    if (is_write_s) begin
      case (reg_idx_s)
        REG_OUT:     out_nxt_s = (out_r & ~wmask_s) | wdata_s;
        REG_OE:      oe_nxt_s  = (oe_r & ~wmask_s) | wdata_s;
        REG_OUT_SET: out_nxt_s = out_r | wdata_s;
        REG_OUT_CLR: out_nxt_s = out_r & ~wdata_s;
        default: begin
          out_nxt_s = out_r;
          oe_nxt_s  = oe_r;
        end
      endcase
    end else begin
      out_nxt_s = out_r;
      oe_nxt_s  = oe_r;
    end
  end

  // Core registers, input synchronizer and the single-entry D-channel response
  always_ff @(posedge gpio_clock_i or negedge gpio_reset_ni) begin
    if (!gpio_reset_ni) begin
      out_r      <= {WIDTH{1'b0}};
      oe_r       <= {WIDTH{1'b0}};
      in_meta_r  <= {WIDTH{1'b0}};
      in_sync_r  <= {WIDTH{1'b0}};
      d_valid_r  <= 1'b0;
      d_denied_r <= 1'b0;
      d_opcode_r <= 3'd0;
      d_size_r   <= 4'd0;
      d_source_r <= {TL_RS{1'b0}};
      d_data_r   <= 32'd0;
    end else begin
      out_r     <= out_nxt_s;
      oe_r      <= oe_nxt_s;
      in_meta_r <= inputs_i;
      in_sync_r <= in_meta_r;
      if (accept_s) begin
        d_valid_r  <= 1'b1;
        d_denied_r <= !legal_s;
        d_opcode_r <= is_read_s ? OP_ACK_DATA : OP_ACK;
        d_size_r   <= gpio_a_size;
        d_source_r <= gpio_a_source;
        d_data_r   <= is_read_s ? rdata_s : 32'd0;
      end else if (gpio_d_ready) begin
        d_valid_r  <= 1'b0;
      end else begin
        d_valid_r  <= d_valid_r;
      end
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] irq_en_r, irq_pend_r, irq_rise_r, in_prev_r;
  logic [WIDTH-1:0] edge_s, w1c_s, en_nxt_s, rise_nxt_s;
  logic             irq_r;

  // A fresh edge wins over a same-cycle W1C because it is OR-ed in after the clear
  assign edge_s = (irq_rise_r & in_sync_r & ~in_prev_r) | (~irq_rise_r & ~in_sync_r & in_prev_r);

  // Interrupt register write decode
  always_comb begin
    en_nxt_s   = irq_en_r;
    rise_nxt_s = irq_rise_r;
    w1c_s      = {WIDTH{1'b0}};
    if (is_write_s) begin
      case (reg_idx_s)
        REG_IRQ_EN:   en_nxt_s   = (irq_en_r & ~wmask_s) | wdata_s;
        REG_IRQ_PEND: w1c_s      = wdata_s;
        REG_IRQ_RISE: rise_nxt_s = (irq_rise_r & ~wmask_s) | wdata_s;
        default: begin
          en_nxt_s   = irq_en_r;
          rise_nxt_s = irq_rise_r;
          w1c_s      = {WIDTH{1'b0}};
        end
      endcase
    end else begin
      en_nxt_s   = irq_en_r;
      rise_nxt_s = irq_rise_r;
      w1c_s      = {WIDTH{1'b0}};
    end
  end

  // Interrupt state, edge history and the registered interrupt line
  always_ff @(posedge gpio_clock_i or negedge gpio_reset_ni) begin
    if (!gpio_reset_ni) begin
      irq_en_r   <= {WIDTH{1'b0}};
      irq_pend_r <= {WIDTH{1'b0}};
      irq_rise_r <= {WIDTH{1'b0}};
      in_prev_r  <= {WIDTH{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      irq_en_r   <= en_nxt_s;
      irq_rise_r <= rise_nxt_s;
      irq_pend_r <= (irq_pend_r & ~w1c_s) | edge_s;
      in_prev_r  <= in_sync_r;
      irq_r      <= |(irq_pend_r & irq_en_r);
    end
  end

  assign irq_en_s   = irq_en_r;
  assign irq_pend_s = irq_pend_r;
  assign irq_rise_s = irq_rise_r;
  assign irq_o      = irq_r;
`else
  assign irq_en_s   = {WIDTH{1'b0}};
  assign irq_pend_s = {WIDTH{1'b0}};
  assign irq_rise_s = {WIDTH{1'b0}};
  assign irq_o      = 1'b0;
`endif

  assign gpio_a_ready   = a_ready_s;
  assign gpio_d_valid   = d_valid_r;
  assign gpio_d_opcode  = d_opcode_r;
  assign gpio_d_param   = 2'd0;
  assign gpio_d_size    = d_size_r;
  assign gpio_d_source  = d_source_r;
  assign gpio_d_denied  = d_denied_r;
  assign gpio_d_data    = d_data_r;
  assign gpio_d_corrupt = 1'b0;
  assign outputs_o      = out_r;
  assign oe_o           = oe_r;
endmodule

// File: tb/tb_gpio_tlul_irq.sv
// Randomized bench for gpio_tlul_irq with a transaction-level reference model.
module tb_gpio_tlul_irq;
  localparam int WIDTH = 16;
  localparam int TL_RS = 4;
  localparam logic [31:0] PM = 32'((64'd1 << WIDTH) - 64'd1);
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       a_opcode = 3'd0, a_param = 3'd0;
  logic [3:0]       a_size = 4'd2, a_mask = 4'hF;
  logic [TL_RS-1:0] a_source = '0;
  logic [4:0]       a_address = 5'd0;
  logic [31:0]      a_data = 32'd0;
  logic             a_corrupt = 1'b0, a_valid = 1'b0, a_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [3:0]       d_size;
  logic [TL_RS-1:0] d_source;
  logic             d_denied, d_corrupt, d_valid, d_ready = 1'b1;
  logic [31:0]      d_data;
  logic [WIDTH-1:0] outputs_o, oe_o, inputs_i = '0;
  logic             irq_o;

  always #5 clk = ~clk;

  gpio_tlul_irq #(.WIDTH(WIDTH), .TL_RS(TL_RS)) dut (
    .gpio_clock_i(clk), .gpio_reset_ni(rst_n),
    .gpio_a_opcode(a_opcode), .gpio_a_param(a_param), .gpio_a_size(a_size),
    .gpio_a_source(a_source), .gpio_a_address(a_address), .gpio_a_mask(a_mask),
    .gpio_a_data(a_data), .gpio_a_corrupt(a_corrupt), .gpio_a_valid(a_valid),
    .gpio_a_ready(a_ready),
    .gpio_d_opcode(d_opcode), .gpio_d_param(d_param), .gpio_d_size(d_size),
    .gpio_d_source(d_source), .gpio_d_denied(d_denied), .gpio_d_data(d_data),
    .gpio_d_corrupt(d_corrupt), .gpio_d_valid(d_valid), .gpio_d_ready(d_ready),
    .outputs_o(outputs_o), .oe_o(oe_o), .inputs_i(inputs_i), .irq_o(irq_o)
  );

  int n_vec = 0, n_err = 0;

  // Reference model: architectural register values plus the expected D beat
  logic [31:0]      m_out, m_oe, m_en, m_pend, m_rise, m_ddata;
  logic             m_dv, m_irq, m_dden;
  logic [2:0]       m_dop;
  logic [3:0]       m_dsize;
  logic [TL_RS-1:0] m_dsrc;
  logic [31:0]      in_log [0:8191];
  int               cyc = 0, base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = 0; m_oe = 0; m_en = 0; m_pend = 0; m_rise = 0; m_ddata = 0;
    m_dv = 0; m_irq = 0; m_dden = 0; m_dop = 0; m_dsize = 0; m_dsrc = '0;
  endtask

  // Synchronized input seen at edge index cyc is the pin value sampled d edges earlier
  function automatic logic [31:0] insync(input int d);
    int idx = cyc - d;
    if (idx < base) return 32'd0;
    return in_log[idx] & PM;
  endfunction

  task automatic model_step();
    logic        ready, acc, wr;
    logic [2:0]  idx;
    logic [31:0] bm, wd, syn, prv, edges, rdv, w1c, n_out, n_oe, n_en, n_rise, n_pend;
    logic        n_irq;
    in_log[cyc] = 32'(inputs_i);
    syn = insync(2);
    prv = insync(3);
    ready = !m_dv || d_ready;
    acc = a_valid && ready;
    wr = acc && (a_opcode == 3'd0 || a_opcode == 3'd1);
    idx = a_address[4:2];
    bm = {{8{a_mask[3]}}, {8{a_mask[2]}}, {8{a_mask[1]}}, {8{a_mask[0]}}} & PM;
    wd = a_data & bm;
    case (idx)
      3'd0: rdv = m_out;
      3'd1: rdv = syn;
      3'd2: rdv = m_oe;
      3'd5: rdv = m_en;
      3'd6: rdv = m_pend;
      3'd7: rdv = m_rise;
      default: rdv = 32'd0;
    endcase
    n_out = m_out; n_oe = m_oe; n_en = m_en; n_rise = m_rise; w1c = 32'd0;
    if (wr) begin
      case (idx)
        3'd0: n_out = (m_out & ~bm) | wd;
        3'd2: n_oe = (m_oe & ~bm) | wd;
        3'd3: n_out = m_out | wd;
        3'd4: n_out = m_out & ~wd;
        3'd5: if (IRQ_ON) n_en = (m_en & ~bm) | wd;
        3'd6: if (IRQ_ON) w1c = wd;
        3'd7: if (IRQ_ON) n_rise = (m_rise & ~bm) | wd;
        default: ;
      endcase
    end
    edges = IRQ_ON ? (((m_rise & syn & ~prv) | (~m_rise & ~syn & prv)) & PM) : 32'd0;
    n_irq = IRQ_ON ? |(m_pend & m_en) : 1'b0;
    n_pend = (m_pend & ~w1c) | edges;
    if (acc) begin
      m_dv = 1'b1;
      m_dden = !(a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == 3'd4);
      m_dop = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
      m_dsize = a_size;
      m_dsrc = a_source;
      m_ddata = (a_opcode == 3'd4) ? rdv : 32'd0;
    end else if (d_ready) begin
      m_dv = 1'b0;
    end
    m_out = n_out; m_oe = n_oe; m_en = n_en; m_rise = n_rise; m_pend = n_pend; m_irq = n_irq;
    cyc++;
  endtask

  task automatic compare();
    chk("outputs_o", 32'(outputs_o), m_out);
    chk("oe_o", 32'(oe_o), m_oe);
    chk("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
    chk("a_ready", {31'd0, a_ready}, {31'd0, (!m_dv || d_ready)});
    chk("d_valid", {31'd0, d_valid}, {31'd0, m_dv});
    if (m_dv) begin
      chk("d_opcode", {29'd0, d_opcode}, {29'd0, m_dop});
      chk("d_denied", {31'd0, d_denied}, {31'd0, m_dden});
      chk("d_size", {28'd0, d_size}, {28'd0, m_dsize});
      chk("d_source", 32'(d_source), 32'(m_dsrc));
      chk("d_param", {30'd0, d_param}, 32'd0);
      chk("d_corrupt", {31'd0, d_corrupt}, 32'd0);
      if (m_dop == 3'd1) chk("d_data", d_data, m_ddata);
    end
  endtask

  task automatic do_cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [4:0] addr, input logic [3:0] mask,
                     input logic [31:0] data);
    a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
    a_size = 4'd2; a_source = a_source + 4'd1; a_valid = 1'b1; d_ready = 1'b1;
    do_cycle();
    a_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (3) do_cycle();
    chk("rst_outputs", 32'(outputs_o), 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    rst_n = 1'b1; base = cyc;
    do_cycle();
    chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);

    // PutFull then Get of OUT
    req(3'd0, 5'h00, 4'hF, 32'h0000A5A5);
    chk("put_ack_op", {29'd0, d_opcode}, 32'd0);
    chk("put_out_pins", 32'(outputs_o), 32'h0000A5A5);
    req(3'd4, 5'h00, 4'hF, 32'd0);
    chk("get_ackdata_op", {29'd0, d_opcode}, 32'd1);
    chk("get_out_data", d_data, 32'h0000A5A5);

    // SET / CLR arithmetic
    req(3'd0, 5'h00, 4'hF, 32'h000000F0);
    req(3'd0, 5'h0C, 4'hF, 32'h0000000F);
    req(3'd0, 5'h10, 4'hF, 32'h00000080);
    chk("set_clr_pins", 32'(outputs_o), 32'h0000007F);
    req(3'd4, 5'h0C, 4'hF, 32'd0);
    chk("get_out_set", d_data, 32'd0);

    // Partial write of the low byte of OE
    req(3'd1, 5'h08, 4'b0001, 32'hFFFFFFFF);
    chk("partial_oe", 32'(oe_o), 32'h000000FF);

    // Back-pressure: response held for five cycles, new request refused
    req(3'd4, 5'h00, 4'hF, 32'd0);
    d_ready = 1'b0;
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 5'h08;
    for (int k = 0; k < 5; k++) begin
      do_cycle();
      chk("stall_a_ready", {31'd0, a_ready}, 32'd0);
      chk("stall_d_data", d_data, 32'h0000007F);
    end
    a_valid = 1'b0; d_ready = 1'b1;
    do_cycle();
    chk("single_resp", {31'd0, d_valid}, 32'd0);

    // Illegal opcode denied with no state change
    req(3'd2, 5'h00, 4'hF, 32'h00001234);
    chk("denied", {31'd0, d_denied}, 32'd1);
    chk("denied_op", {29'd0, d_opcode}, 32'd0);
    chk("denied_pins", 32'(outputs_o), 32'h0000007F);

`ifdef GPIO_IRQ_EN
    req(3'd0, 5'h14, 4'hF, 32'd1);
    req(3'd0, 5'h1C, 4'hF, 32'd1);
    inputs_i = 16'h0001;
    repeat (4) do_cycle();
    chk("irq_set", {31'd0, irq_o}, 32'd1);
    req(3'd4, 5'h18, 4'hF, 32'd0);
    chk("irq_pend", d_data, 32'd1);
    req(3'd0, 5'h18, 4'hF, 32'd1);
    do_cycle();
    chk("irq_w1c", {31'd0, irq_o}, 32'd0);
`else
    req(3'd0, 5'h14, 4'hF, 32'd1);
    req(3'd4, 5'h14, 4'hF, 32'd0);
    chk("irq_en_absent", d_data, 32'd0);
    chk("irq_tied", {31'd0, irq_o}, 32'd0);
`endif

    // Reset with a response pending
    req(3'd4, 5'h00, 4'hF, 32'd0);
    d_ready = 1'b0;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_drop_resp", {31'd0, d_valid}, 32'd0);
    do_cycle();
    do_cycle();
    rst_n = 1'b1; base = cyc;
    do_cycle();
    chk("rst_no_resp", {31'd0, d_valid}, 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2: a_opcode = 3'd0;
        3, 4:    a_opcode = 3'd1;
        5, 6:    a_opcode = 3'd4;
        default: a_opcode = 3'($urandom_range(5, 7));
      endcase
      if (r == 7 && $urandom_range(0, 1) == 0) a_opcode = 3'($urandom_range(2, 3));
      a_address = 5'($urandom);
      a_mask = 4'($urandom);
      a_data = $urandom;
      a_size = 4'($urandom);
      a_source = 4'($urandom);
      a_valid = ($urandom_range(0, 9) < 6);
      d_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) inputs_i = WIDTH'($urandom);
      if (i == 700) begin
        rst_n = 1'b0;
        m_reset();
        do_cycle();
        do_cycle();
        rst_n = 1'b1; base = cyc;
      end
      do_cycle();
    end
    a_valid = 1'b0; d_ready = 1'b1;
    repeat (3) do_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
